// File: rtl/softex_pkg.sv
// Shared definitions for the softex stream tracker: FSM state encoding and
// the default element-counter width.
package softex_pkg;

  localparam int unsigned SOFTEX_CNT_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } softex_state_e;

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// Minimal valid/ready stream interface carrying a data payload and a byte
// strobe, with source and sink views.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) ();

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [STRB_WIDTH-1:0] strb;

  modport source (output valid, output data, output strb, input ready);
  modport sink   (input valid, input data, input strb, output ready);

endinterface

// File: rtl/softex_stream_buf.sv
// Two-entry registered FIFO carrying data, strobe and a last flag.
// Output fields come straight from storage, so they stay stable while the
// consumer stalls. Input ready depends only on occupancy.
module softex_stream_buf #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic [STRB_WIDTH-1:0] in_strb_i,
  input  logic                  in_last_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic [STRB_WIDTH-1:0] out_strb_o,
  output logic                  out_last_o
);

  logic [DATA_WIDTH-1:0] data_q [2];
  logic [STRB_WIDTH-1:0] strb_q [2];
  logic [1:0]            last_q;
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            cnt_q, cnt_d;
  logic                  push, pop;

  assign in_ready_o  = (cnt_q != 2'd2);
  assign out_valid_o = (cnt_q != 2'd0);
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;

  assign out_data_o  = data_q[rd_ptr_q];
  assign out_strb_o  = strb_q[rd_ptr_q];
  assign out_last_o  = last_q[rd_ptr_q];

  // Occupancy update; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy registers; reset flushes the buffer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_d;
    end
  end

  // Payload storage; contents are don't-care while the entry is empty.
  always_ff @(posedge clk_i) begin
    if (push) begin
      data_q[wr_ptr_q] <= in_data_i;
      strb_q[wr_ptr_q] <= in_strb_i;
      last_q[wr_ptr_q] <= in_last_i;
    end
  end

endmodule

// File: rtl/softex_stream_tracker.sv
// Softex stream tracker: counts valid elements of incoming beats against a
// latched vector length, tags the beat that reaches the length as last, and
// forwards beats through a 2-entry buffer.
// Optional feature: define SOFTEX_STREAM_TRACKER_PERF_EN to add stall_cnt_o,
// a saturating count of RUN cycles where the output is stalled.
//
// state   | meaning
// IDLE    | waiting for start_i
// RUN     | accepting and forwarding beats of the current vector
// DONE    | one-cycle done_o pulse, then back to IDLE
module softex_stream_tracker
  import softex_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned ELEM_WIDTH = 16,
  parameter int unsigned CNT_WIDTH  = SOFTEX_CNT_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 start_i,
  input  logic [CNT_WIDTH-1:0] len_i,
  hwpe_stream_intf_stream.sink   stream_i,
  hwpe_stream_intf_stream.source stream_o,
  output logic                 last_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 excess_o
`ifdef SOFTEX_STREAM_TRACKER_PERF_EN
  ,
  output logic [31:0]          stall_cnt_o
`endif
);

  localparam int unsigned NLANES     = DATA_WIDTH / ELEM_WIDTH;
  localparam int unsigned BPE        = ELEM_WIDTH / 8;
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned LCW        = $clog2(NLANES + 1);

  softex_state_e        state_q, state_d;
  logic [CNT_WIDTH-1:0] len_q, len_d;
  logic [CNT_WIDTH-1:0] acc_q, acc_d;
  logic                 excess_q, excess_d;
  logic                 last_seen_q, last_seen_d;

  logic [LCW-1:0]       beat_cnt;
  logic [CNT_WIDTH:0]   sum;
  logic                 beat_last, beat_over;
  logic                 soft_rst;
  logic                 in_open, buf_in_ready, in_accept;
  logic                 out_valid, out_last, out_accept;

  assign soft_rst = rst_i | clear_i;

  // An element is valid when the strobe bit of its lowest byte is set.
  always_comb begin
    beat_cnt = '0;
    for (int k = 0; k < NLANES; k++) begin
      beat_cnt = beat_cnt + LCW'(stream_i.strb[k*BPE]);
    end
  end

  // One extra bit so that overflow is visible for saturation.
  assign sum       = {1'b0, acc_q} + (CNT_WIDTH+1)'(beat_cnt);
  assign beat_last = (sum >= {1'b0, len_q});
  assign beat_over = (sum >  {1'b0, len_q});

  // No further beats are taken once the last one is in the buffer.
  assign in_open        = (state_q == ST_RUN) && !last_seen_q;
  assign stream_i.ready = in_open && buf_in_ready;
  assign in_accept      = stream_i.valid && stream_i.ready;

  softex_stream_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .STRB_WIDTH (STRB_WIDTH)
  ) i_buf (
    .clk_i       (clk_i),
    .rst_i       (soft_rst),
    .in_valid_i  (stream_i.valid && in_open),
    .in_ready_o  (buf_in_ready),
    .in_data_i   (stream_i.data),
    .in_strb_i   (stream_i.strb),
    .in_last_i   (beat_last),
    .out_valid_o (out_valid),
    .out_ready_i (stream_o.ready),
    .out_data_o  (stream_o.data),
    .out_strb_o  (stream_o.strb),
    .out_last_o  (out_last)
  );

  assign stream_o.valid = out_valid;
  assign out_accept     = out_valid && stream_o.ready;
  assign last_o         = out_valid && out_last;
  assign busy_o         = (state_q == ST_RUN);
  assign done_o         = (state_q == ST_DONE);
  assign excess_o       = excess_q;

  // Next-state and per-vector bookkeeping.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    acc_d       = acc_q;
    excess_d    = excess_q;
    last_seen_d = last_seen_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          len_d       = len_i;
          acc_d       = '0;
          excess_d    = 1'b0;
          last_seen_d = 1'b0;
          state_d     = (len_i == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (in_accept) begin
          acc_d = sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
          if (beat_over) excess_d = 1'b1;
          if (beat_last) last_seen_d = 1'b1;
        end
        if (out_accept && out_last) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset and soft clear behave identically.
  always_ff @(posedge clk_i) begin
    if (soft_rst) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      acc_q       <= '0;
      excess_q    <= 1'b0;
      last_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      acc_q       <= acc_d;
      excess_q    <= excess_d;
      last_seen_q <= last_seen_d;
    end
  end

`ifdef SOFTEX_STREAM_TRACKER_PERF_EN
  logic [31:0] stall_q, stall_d;

  // Saturating stall counter, restarted with each vector.
  always_comb begin
    stall_d = stall_q;
    if ((state_q == ST_IDLE) && start_i) begin
      stall_d = '0;
    end else if ((state_q == ST_RUN) && out_valid && !stream_o.ready &&
                 (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk_i) begin
    if (soft_rst) stall_q <= '0;
    else          stall_q <= stall_d;
  end

  assign stall_cnt_o = stall_q;
`endif

endmodule
